eth_mon_seq: RTL and testbench

//  Test sequencer that drives the Ethernet packet monitor's 3-bit register bus: it programs the expected

---
 rtl/eth_mon_seq_pkg.sv | 36 +++
 rtl/eth_mon_seq_timer.sv | 44 ++++
 rtl/eth_mon_seq.sv | 174 +++++++++++++++++
 tb/tb_eth_mon_seq.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_mon_seq_pkg.sv
// Shared definitions for the Ethernet monitor test sequencer: monitor register map,
// ctrl/status bit positions, ctrl write values and FSM state encodings.
package eth_mon_seq_pkg;

    localparam logic [2:0] ADDR_NUM_PKT  = 3'd0;
    localparam logic [2:0] ADDR_RX_OK    = 3'd1;
    localparam logic [2:0] ADDR_RX_ERR   = 3'd2;
    localparam logic [2:0] ADDR_BYTES_LO = 3'd3;
    localparam logic [2:0] ADDR_BYTES_HI = 3'd4;
    localparam logic [2:0] ADDR_CYC_LO   = 3'd5;
    localparam logic [2:0] ADDR_CYC_HI   = 3'd6;
    localparam logic [2:0] ADDR_CTRL     = 3'd7;

    localparam int CTRL_START_BIT   = 0;
    localparam int CTRL_STOP_BIT    = 1;
    localparam int STAT_RX_DONE_BIT = 2;

    localparam logic [31:0] CTRL_START   = 32'd1 << CTRL_START_BIT;
    localparam logic [31:0] CTRL_RELEASE = 32'd0;
    localparam logic [31:0] CTRL_STOP    = 32'd1 << CTRL_STOP_BIT;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_WR_NUM = 4'd1;
    localparam logic [3:0] S_WR_STA = 4'd2;
    localparam logic [3:0] S_WR_REL = 4'd3;
    localparam logic [3:0] S_POLL   = 4'd4;
    localparam logic [3:0] S_RD_OK  = 4'd5;
    localparam logic [3:0] S_RD_ERR = 4'd6;
    localparam logic [3:0] S_RD_BLO = 4'd7;
    localparam logic [3:0] S_RD_BHI = 4'd8;
    localparam logic [3:0] S_RD_CLO = 4'd9;
    localparam logic [3:0] S_RD_CHI = 4'd10;
    localparam logic [3:0] S_STOP   = 4'd11;
    localparam logic [3:0] S_FIN    = 4'd12;

endpackage

// File: rtl/eth_mon_seq_timer.sv
// Poll pacing for the sequencer: a reloading poll-gap down-counter and a saturating
// timeout up-counter, both restarted by clr on the cycle before POLL is entered.
module eth_mon_seq_timer #(
    parameter logic [31:0] POLL_GAP       = 32'd16,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    output logic gap_hit,
    output logic to_hit
);

    localparam logic [31:0] TO_LAST = TIMEOUT_CYCLES - 32'd1;

    logic [31:0] gap_q, gap_d;
    logic [31:0] to_q, to_d;

    // gap_hit marks the read cycle; the counter reloads itself so reads repeat every POLL_GAP+1 cycles
    always_comb begin
        gap_d = (clr || gap_q == '0) ? POLL_GAP : gap_q - 32'd1;
        if (clr) begin
            to_d = '0;
        end else if (to_q == '1) begin
            to_d = to_q;
        end else begin
            to_d = to_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gap_q <= '0;
            to_q  <= '0;
        end else begin
            gap_q <= gap_d;
            to_q  <= to_d;
        end
    end

    assign gap_hit = (gap_q == '0);
    assign to_hit  = (to_q >= TO_LAST);

endmodule

// File: rtl/eth_mon_seq.sv
// Test sequencer for the Ethernet packet monitor register bus: program, start, poll, read back, stop.
// Define ETH_MON_SEQ_CYCLE_RD_EN to also read and capture the monitor's cycle counter.
module eth_mon_seq
    import eth_mon_seq_pkg::*;
#(
    parameter logic [31:0] POLL_GAP       = 32'd16,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] num_packets,
    output logic [2:0]  mon_address,
    output logic        mon_write,
    output logic        mon_read,
    output logic [31:0] mon_writedata,
    input  logic [31:0] mon_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic        cfg_err,
    output logic [31:0] ok_count,
    output logic [31:0] err_count,
    output logic [63:0] byte_count,
    output logic [63:0] cycle_count
);

    logic [3:0]  state_q, state_d;
    logic [31:0] num_q, ok_q, err_q;
    logic [63:0] bytes_q;
    logic        timeout_q, cfg_err_q, abort_seen_q, pass_q;
`ifdef ETH_MON_SEQ_CYCLE_RD_EN
    logic [63:0] cyc_q;
`endif

    logic gap_hit, to_hit;
    logic idle_like, accept, abortable, rx_done_rd, timeout_set;

    eth_mon_seq_timer #(
        .POLL_GAP       (POLL_GAP),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state_q == S_WR_REL),
        .gap_hit (gap_hit),
        .to_hit  (to_hit)
    );

    // FIN also accepts a new start since busy is already low there
    assign idle_like   = (state_q == S_IDLE) || (state_q == S_FIN);
    assign accept      = start && idle_like;
    assign abortable   = !idle_like && (state_q != S_STOP);
    assign rx_done_rd  = (state_q == S_POLL) && gap_hit && mon_readdata[STAT_RX_DONE_BIT];
    assign timeout_set = (state_q == S_POLL) && to_hit && !rx_done_rd;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_FIN: begin
                if (start) state_d = (num_packets != '0) ? S_WR_NUM : S_FIN;
                else       state_d = S_IDLE;
            end
            S_WR_NUM: state_d = S_WR_STA;
            S_WR_STA: state_d = S_WR_REL;
            S_WR_REL: state_d = S_POLL;
            S_POLL: begin
                if (rx_done_rd)  state_d = S_RD_OK;
                else if (to_hit) state_d = S_STOP;
            end
            S_RD_OK:  state_d = S_RD_ERR;
            S_RD_ERR: state_d = S_RD_BLO;
            S_RD_BLO: state_d = S_RD_BHI;
`ifdef ETH_MON_SEQ_CYCLE_RD_EN
            S_RD_BHI: state_d = S_RD_CLO;
            S_RD_CLO: state_d = S_RD_CHI;
            S_RD_CHI: state_d = S_STOP;
`else
            S_RD_BHI: state_d = S_STOP;
`endif
            S_STOP:   state_d = S_FIN;
            default:  state_d = S_IDLE;
        endcase
        // the access of the current state still completes; only the successor changes
        if (abortable && abort) state_d = S_STOP;
    end

    always_comb begin
        mon_address   = '0;
        mon_write     = 1'b0;
        mon_read      = 1'b0;
        mon_writedata = '0;
        case (state_q)
            S_WR_NUM: begin mon_address = ADDR_NUM_PKT; mon_write = 1'b1; mon_writedata = num_q;        end
            S_WR_STA: begin mon_address = ADDR_CTRL;    mon_write = 1'b1; mon_writedata = CTRL_START;   end
            S_WR_REL: begin mon_address = ADDR_CTRL;    mon_write = 1'b1; mon_writedata = CTRL_RELEASE; end
            S_POLL: begin
                if (gap_hit) begin
                    mon_address = ADDR_CTRL;
                    mon_read    = 1'b1;
                end
            end
            S_RD_OK:  begin mon_address = ADDR_RX_OK;    mon_read = 1'b1; end
            S_RD_ERR: begin mon_address = ADDR_RX_ERR;   mon_read = 1'b1; end
            S_RD_BLO: begin mon_address = ADDR_BYTES_LO; mon_read = 1'b1; end
            S_RD_BHI: begin mon_address = ADDR_BYTES_HI; mon_read = 1'b1; end
            S_RD_CLO: begin mon_address = ADDR_CYC_LO;   mon_read = 1'b1; end
            S_RD_CHI: begin mon_address = ADDR_CYC_HI;   mon_read = 1'b1; end
            S_STOP:   begin mon_address = ADDR_CTRL;    mon_write = 1'b1; mon_writedata = CTRL_STOP;    end
            default: ;
        endcase
    end

    // timeout and cfg_err stay set until the next accepted start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            num_q        <= '0;
            ok_q         <= '0;
            err_q        <= '0;
            bytes_q      <= '0;
            timeout_q    <= 1'b0;
            cfg_err_q    <= 1'b0;
            abort_seen_q <= 1'b0;
            pass_q       <= 1'b0;
`ifdef ETH_MON_SEQ_CYCLE_RD_EN
            cyc_q        <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                num_q        <= num_packets;
                cfg_err_q    <= (num_packets == '0);
                timeout_q    <= 1'b0;
                abort_seen_q <= 1'b0;
                pass_q       <= 1'b0;
            end
            if (timeout_set)        timeout_q    <= 1'b1;
            if (abortable && abort) abort_seen_q <= 1'b1;
            case (state_q)
                S_RD_OK:  ok_q           <= mon_readdata;
                S_RD_ERR: err_q          <= mon_readdata;
                S_RD_BLO: bytes_q[31:0]  <= mon_readdata;
                S_RD_BHI: bytes_q[63:32] <= mon_readdata;
`ifdef ETH_MON_SEQ_CYCLE_RD_EN
                S_RD_CLO: cyc_q[31:0]    <= mon_readdata;
                S_RD_CHI: cyc_q[63:32]   <= mon_readdata;
`endif
                default: ;
            endcase
            if (state_q == S_FIN) begin
                pass_q <= !timeout_q && !abort_seen_q && !cfg_err_q &&
                          (err_q == '0) && (ok_q == num_q);
            end
        end
    end

    assign busy       = !idle_like;
    assign done       = (state_q == S_FIN);
    assign pass       = pass_q;
    assign timeout    = timeout_q;
    assign cfg_err    = cfg_err_q;
    assign ok_count   = ok_q;
    assign err_count  = err_q;
    assign byte_count = bytes_q;
`ifdef ETH_MON_SEQ_CYCLE_RD_EN
    assign cycle_count = cyc_q;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_eth_mon_seq.sv
// Directed bench for eth_mon_seq with a behavioural monitor register model.
module tb_eth_mon_seq;

    localparam logic [31:0] GAP = 32'd4;
    localparam logic [31:0] TO  = 32'd200;
`ifdef ETH_MON_SEQ_CYCLE_RD_EN
    localparam int NRD = 6;
`else
    localparam int NRD = 4;
`endif

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [31:0] num_packets;
    logic [2:0]  mon_address;
    logic        mon_write;
    logic        mon_read;
    logic [31:0] mon_writedata;
    logic [31:0] mon_readdata;
    logic        busy, done, pass, timeout, cfg_err;
    logic [31:0] ok_count, err_count;
    logic [63:0] byte_count, cycle_count;

    eth_mon_seq #(
        .POLL_GAP       (GAP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .abort         (abort),
        .num_packets   (num_packets),
        .mon_address   (mon_address),
        .mon_write     (mon_write),
        .mon_read      (mon_read),
        .mon_writedata (mon_writedata),
        .mon_readdata  (mon_readdata),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .cfg_err       (cfg_err),
        .ok_count      (ok_count),
        .err_count     (err_count),
        .byte_count    (byte_count),
        .cycle_count   (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [34:0] wlog[$];
    int rd_cnt = 0, poll_cnt = 0, done_cnt = 0, ovl_cnt = 0;
    int wbase = 0, rbase = 0, pbase = 0, dbase = 0;
    logic [31:0] m_ok = '0, m_err = '0;
    logic [63:0] m_bytes = '0, m_cyc = '0;
    int m_done_at = 0;

    // monitor bus observer
    always @(posedge clk) begin
        if (mon_write) wlog.push_back({mon_address, mon_writedata});
        if (mon_read) rd_cnt <= rd_cnt + 1;
        if (mon_read && mon_address == 3'd7) poll_cnt <= poll_cnt + 1;
        if (mon_read && mon_write) ovl_cnt <= ovl_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    // zero-wait monitor register model; rx_done rises on poll number m_done_at (0 = never)
    always_comb begin
        mon_readdata = '0;
        case (mon_address)
            3'd1: mon_readdata = m_ok;
            3'd2: mon_readdata = m_err;
            3'd3: mon_readdata = m_bytes[31:0];
            3'd4: mon_readdata = m_bytes[63:32];
            3'd5: mon_readdata = m_cyc[31:0];
            3'd6: mon_readdata = m_cyc[63:32];
            3'd7: mon_readdata[2] = (m_done_at != 0) && ((poll_cnt - pbase + 1) >= m_done_at);
            default: mon_readdata = '0;
        endcase
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [31:0] num, input logic ab);
        wbase = wlog.size();
        rbase = rd_cnt;
        pbase = poll_cnt;
        dbase = done_cnt;
        num_packets = num;
        start = 1'b1;
        abort = ab;
        tick();
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (done !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
    endtask

    int n;
    logic [63:0] exp_cyc;

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        num_packets = '0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_strobes", {mon_write, mon_read}, 0);
        chk("rst_addr_data", {mon_address, mon_writedata}, 0);
        chk("rst_captures", {ok_count, err_count, byte_count, cycle_count}, 0);
        chk("rst_flags", {timeout, cfg_err}, 0);
        reset_n = 1'b1;
        tick();

        // run 1: num=5, rx_done on 3rd poll, clean counters
        m_ok = 32'd5; m_err = 32'd0; m_bytes = 64'h1234; m_cyc = 64'h99; m_done_at = 3;
        start_run(32'd5, 1'b0);
        chk("r1_busy", busy, 1);
        wait_done(1, n);
        chk("r1_latency", n, 20 + NRD);
        chk("r1_busy_fin", busy, 0);
        chk("r1_wr_count", wlog.size() - wbase, 4);
        chk("r1_wr0", wlog[wbase], {3'd0, 32'd5});
        chk("r1_wr1", wlog[wbase + 1], {3'd7, 32'd1});
        chk("r1_wr2", wlog[wbase + 2], {3'd7, 32'd0});
        chk("r1_wr3", wlog[wbase + 3], {3'd7, 32'd2});
        chk("r1_polls", poll_cnt - pbase, 3);
        chk("r1_reads", rd_cnt - rbase, 3 + NRD);
        tick();
        chk("r1_pass", pass, 1);
        chk("r1_done_once", done_cnt - dbase, 1);
        chk("r1_done_low", done, 0);
        chk("r1_ok", ok_count, 5);
        chk("r1_bytes", byte_count, 64'h1234);
`ifdef ETH_MON_SEQ_CYCLE_RD_EN
        exp_cyc = 64'h99;
`else
        exp_cyc = 64'h0;
`endif
        chk("r1_cycles", cycle_count, exp_cyc);

        // run 2: errors reported; a second start while busy must be dropped
        m_ok = 32'd3; m_err = 32'd1; m_bytes = 64'h1_0000_0040; m_done_at = 1;
        start_run(32'd4, 1'b0);
        tick();
        num_packets = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(3, n);
        chk("r2_latency", n, 10 + NRD);
        chk("r2_cfg_err", cfg_err, 0);
        chk("r2_wr0", wlog[wbase], {3'd0, 32'd4});
        tick();
        chk("r2_pass", pass, 0);
        chk("r2_err", err_count, 1);
        chk("r2_ok", ok_count, 3);
        chk("r2_bytes", byte_count, 64'h1_0000_0040);

        // run 3: rx_done never set -> timeout after 200 POLL cycles
        m_done_at = 0;
        start_run(32'd7, 1'b0);
        wait_done(1, n);
        chk("r3_latency", n, 205);
        chk("r3_timeout", timeout, 1);
        chk("r3_wr_count", wlog.size() - wbase, 4);
        chk("r3_wr3", wlog[wbase + 3], {3'd7, 32'd2});
        chk("r3_reads_polls_only", rd_cnt - rbase, 40);
        tick();
        chk("r3_pass", pass, 0);
        chk("r3_err_kept", err_count, 1);

        // run 4: abort in POLL idle -> STOP write next, done after that
        start_run(32'd2, 1'b0);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("r4_stop_write", mon_write, 1);
        chk("r4_stop_addr_data", {mon_address, mon_writedata}, {3'd7, 32'd2});
        chk("r4_no_reads", rd_cnt - rbase, 0);
        tick();
        chk("r4_done", done, 1);
        tick();
        chk("r4_pass", pass, 0);
        chk("r4_wr_count", wlog.size() - wbase, 4);

        // run 5: num=0 -> cfg_err and done pulse, no bus strobes
        start_run(32'd0, 1'b0);
        chk("r5_done", done, 1);
        chk("r5_busy", busy, 0);
        chk("r5_cfg_err", cfg_err, 1);
        tick();
        chk("r5_pass", pass, 0);
        chk("r5_done_low", done, 0);
        chk("r5_no_writes", wlog.size() - wbase, 0);
        chk("r5_no_reads", rd_cnt - rbase, 0);

        // run 6: async reset while reading rx_err, then start+abort together in IDLE
        m_ok = 32'd5; m_err = 32'd0; m_bytes = 64'h80; m_done_at = 1;
        start_run(32'd5, 1'b0);
        n = 1;
        while (!(mon_read && mon_address == 3'd2) && n < 100) begin
            tick();
            n++;
        end
        chk("r6_reach_rd_err", n, 10);
        reset_n = 1'b0;
        #1;
        chk("r6_rst_busy", busy, 0);
        chk("r6_rst_strobes", {mon_read, mon_write, mon_address}, 0);
        chk("r6_rst_captures", {ok_count, err_count, byte_count}, 0);
        chk("r6_rst_cfg_err", cfg_err, 0);
        #2;
        reset_n = 1'b1;
        tick();
        start_run(32'd5, 1'b1);
        chk("r6_start_wins", {mon_write, mon_address, mon_writedata}, {1'b1, 3'd0, 32'd5});
        wait_done(1, n);
        chk("r6_latency", n, 10 + NRD);
        chk("r6_wr_count", wlog.size() - wbase, 4);
        tick();
        chk("r6_pass", pass, 1);
        chk("r6_ok", ok_count, 5);

        chk("no_rd_wr_overlap", ovl_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
